// File: rtl/qcl_pkg.sv
// Shared helpers for the pulse spacer: sizing of the per-lane cooldown counter.
package qcl_pkg;

  // Cooldown counter must hold gap_p-1; never narrower than one bit.
  function automatic int qcl_gap_width(input int gap);
    return (gap <= 2) ? 1 : $clog2(gap);
  endfunction

endpackage

// File: rtl/qcl_pulse_spacer_if.sv
// Event-in / spaced-pulse-out bundle between the event source and the spacer.
interface qcl_pulse_spacer_if #(
  parameter int width_p = 1
);
  logic               en_i;
  logic [width_p-1:0] pulse_i;
  logic [width_p-1:0] clear_ovf_i;
  logic [width_p-1:0] pulse_o;
  logic [width_p-1:0] busy_o;
  logic [width_p-1:0] overflow_o;

  modport master (
    output en_i, pulse_i, clear_ovf_i,
    input  pulse_o, busy_o, overflow_o
  );

  modport slave (
    input  en_i, pulse_i, clear_ovf_i,
    output pulse_o, busy_o, overflow_o
  );
endinterface

// File: rtl/qcl_pulse_spacer_lane.sv
// One lane: pending-event counter plus cooldown counter; re-emits events as
// single-cycle pulses at least gap_p cycles apart.
module qcl_pulse_spacer_lane
  import qcl_pkg::*;
#(
  parameter int gap_p        = 4,
  parameter int pend_width_p = 4
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic en_i,
  input  logic pulse_i,
  input  logic clear_ovf_i,
  output logic pulse_o,
  output logic busy_o,
  output logic overflow_o
);

  localparam int gcnt_w_lp = qcl_gap_width(gap_p);
  localparam logic [pend_width_p-1:0] cnt_max_lp     = '1;
  localparam logic [pend_width_p-1:0] cnt_one_lp     = pend_width_p'(1);
  localparam logic [gcnt_w_lp-1:0]    gcnt_one_lp    = gcnt_w_lp'(1);
  localparam logic [gcnt_w_lp-1:0]    gcnt_reload_lp = gcnt_w_lp'(gap_p - 1);

  logic [pend_width_p-1:0] cnt_q, cnt_d;
  logic [gcnt_w_lp-1:0]    gcnt_q, gcnt_d;
  logic                    pulse_q, pulse_d;
  logic                    ovf_q, ovf_d;
  logic                    fire;
  logic                    drop;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q   <= '0;
      gcnt_q  <= '0;
      pulse_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      pulse_q <= pulse_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    // An incoming event can fire straight through when the lane is idle.
    fire    = en_i & (gcnt_q == '0) & ((cnt_q != '0) | pulse_i);
    drop    = pulse_i & ~fire & (cnt_q == cnt_max_lp);
    pulse_d = fire;

    cnt_d = cnt_q;
    if (pulse_i && !fire && !drop) begin
      cnt_d = cnt_q + cnt_one_lp;
    end else if (!pulse_i && fire) begin
      cnt_d = cnt_q - cnt_one_lp;
    end

    gcnt_d = gcnt_q;
    if (fire) begin
      gcnt_d = gcnt_reload_lp;
    end else if (gcnt_q != '0) begin
      gcnt_d = gcnt_q - gcnt_one_lp;
    end

    // A drop in the same cycle as a clear wins, so no lost event goes unreported.
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clear_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  assign pulse_o    = pulse_q;
  assign busy_o     = (cnt_q != '0) | (gcnt_q != '0);
  assign overflow_o = ovf_q;

endmodule

// File: rtl/qcl_pulse_spacer.sv
// Multi-lane pulse spacer feeding a pulse CDC synchronizer; lanes are independent.
module qcl_pulse_spacer
  import qcl_pkg::*;
#(
  parameter int width_p      = 1,
  parameter int gap_p        = 4,
  parameter int pend_width_p = 4
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  qcl_pulse_spacer_if.slave bus_if
);

  for (genvar gi = 0; gi < width_p; gi++) begin : g_lane
    qcl_pulse_spacer_lane #(
      .gap_p        (gap_p),
      .pend_width_p (pend_width_p)
    ) u_lane (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .en_i         (bus_if.en_i),
      .pulse_i      (bus_if.pulse_i[gi]),
      .clear_ovf_i  (bus_if.clear_ovf_i[gi]),
      .pulse_o      (bus_if.pulse_o[gi]),
      .busy_o       (bus_if.busy_o[gi]),
      .overflow_o   (bus_if.overflow_o[gi])
    );
  end

endmodule

// File: tb/tb_qcl_pulse_spacer.sv
// Directed bench: three spacer configurations driven from one linear sequence.
module tb_qcl_pulse_spacer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // a: 2 lanes gap 4 pend 4; b: gap 4 pend 2 (max 3); c: gap 1 pass-through
  qcl_pulse_spacer_if #(.width_p(2)) a_if ();
  qcl_pulse_spacer_if #(.width_p(1)) b_if ();
  qcl_pulse_spacer_if #(.width_p(1)) c_if ();

  qcl_pulse_spacer #(.width_p(2), .gap_p(4), .pend_width_p(4)) dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .bus_if(a_if.slave));
  qcl_pulse_spacer #(.width_p(1), .gap_p(4), .pend_width_p(2)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .bus_if(b_if.slave));
  qcl_pulse_spacer #(.width_p(1), .gap_p(1), .pend_width_p(4)) dut_c (
    .clk_i(clk), .reset_n_i(reset_n), .bus_if(c_if.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int cyc, input logic [7:0] obs,
                       input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
    $display("chk %-10s cyc %2d obs %b exp %b", tag, cyc, obs, exp);
  endtask

  // Inputs for cycle k are applied, then outputs of cycle k+1 are compared
  // against bit k+1 of each expectation pattern. obs = {ov0,bz1,bz0,po1,po0}.
  task automatic scen(input string tag, input int dut, input int n,
                      input logic [31:0] en, input logic [31:0] in0,
                      input logic [31:0] in1, input logic [31:0] clr0,
                      input logic [31:0] po0, input logic [31:0] po1,
                      input logic [31:0] bz0, input logic [31:0] bz1,
                      input logic [31:0] ov0);
    logic [7:0] obs;
    logic [7:0] exp;
    for (int k = 0; k < n; k++) begin
      case (dut)
        0: begin
          a_if.en_i = en[k]; a_if.pulse_i = {in1[k], in0[k]};
          a_if.clear_ovf_i = {1'b0, clr0[k]};
        end
        1: begin
          b_if.en_i = en[k]; b_if.pulse_i = in0[k]; b_if.clear_ovf_i = clr0[k];
        end
        default: begin
          c_if.en_i = en[k]; c_if.pulse_i = in0[k]; c_if.clear_ovf_i = clr0[k];
        end
      endcase
      tick();
      case (dut)
        0: obs = {3'b000, a_if.overflow_o[0], a_if.busy_o[1], a_if.busy_o[0],
                  a_if.pulse_o[1], a_if.pulse_o[0]};
        1: obs = {3'b000, b_if.overflow_o[0], 1'b0, b_if.busy_o[0], 1'b0, b_if.pulse_o[0]};
        default: obs = {3'b000, c_if.overflow_o[0], 1'b0, c_if.busy_o[0], 1'b0, c_if.pulse_o[0]};
      endcase
      exp = {3'b000, ov0[k+1], bz1[k+1], bz0[k+1], po1[k+1], po0[k+1]};
      check(tag, k + 1, obs, exp);
    end
    a_if.pulse_i = '0; a_if.clear_ovf_i = '0; a_if.en_i = 1'b1;
    b_if.pulse_i = '0; b_if.clear_ovf_i = '0; b_if.en_i = 1'b1;
    c_if.pulse_i = '0; c_if.clear_ovf_i = '0; c_if.en_i = 1'b1;
  endtask

  function automatic logic [7:0] all_outs();
    return {a_if.pulse_o, a_if.busy_o, a_if.overflow_o[0], b_if.pulse_o,
            b_if.busy_o, b_if.overflow_o};
  endfunction

  initial begin
    a_if.en_i = 1'b1; a_if.pulse_i = '0; a_if.clear_ovf_i = '0;
    b_if.en_i = 1'b1; b_if.pulse_i = '0; b_if.clear_ovf_i = '0;
    c_if.en_i = 1'b1; c_if.pulse_i = '0; c_if.clear_ovf_i = '0;

    tick();
    tick();
    check("reset_a_b", 0, all_outs(), 8'h00);
    check("reset_c", 0, {5'b0, c_if.pulse_o, c_if.busy_o, c_if.overflow_o}, 8'h00);
    reset_n = 1'b1;
    tick();

    // single event lane 0 at t, lane 1 at t+2 (independent cooldowns)
    scen("single", 0, 6, 32'hFFFF_FFFF, 32'h1, 32'h4, 32'h0,
         32'h2, 32'h8, 32'hE, 32'h38, 32'h0);
    // three-event burst: pulses at t+1, t+5, t+9; idle from t+12
    scen("burst", 0, 13, 32'hFFFF_FFFF, 32'h7, 32'h0, 32'h0,
         32'h222, 32'h0, 32'hFFE, 32'h0, 32'h0);
    // six events into a 3-deep counter: one dropped, overflow t+6..t+20
    scen("overflow", 1, 21, 32'hFFFF_FFFF, 32'h3F, 32'h0, 32'h10_0000,
         32'h2_2222, 32'h0, 32'hF_FFFE, 32'h0, 32'h1F_FFC0);
    // events held while disabled, released from t+10
    scen("en_gate", 0, 23, 32'hFFFF_FC00, 32'h7, 32'h0, 32'h0,
         32'h8_8800, 32'h0, 32'h3F_FFFE, 32'h0, 32'h0);
    // gap 1: level-high input passes straight through, never busy
    scen("gap1", 2, 6, 32'hFFFF_FFFF, 32'hF, 32'h0, 32'h0,
         32'h1E, 32'h0, 32'h0, 32'h0, 32'h0);

    // async reset mid-cycle on a saturated, overflowed backlog
    b_if.en_i = 1'b0;
    b_if.pulse_i = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    b_if.pulse_i = 1'b0;
    check("rst_pre", 4, {5'b0, b_if.pulse_o, b_if.busy_o, b_if.overflow_o}, 8'h03);
    b_if.en_i = 1'b1;
    tick();
    check("rst_fire", 5, {5'b0, b_if.pulse_o, b_if.busy_o, b_if.overflow_o}, 8'h07);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async", 5, {5'b0, b_if.pulse_o, b_if.busy_o, b_if.overflow_o}, 8'h00);
    #2;
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rst_after", 6 + k, {5'b0, b_if.pulse_o, b_if.busy_o, b_if.overflow_o}, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/qcl_pulse_spacer.md
Name: qcl_pulse_spacer

Overview:
- Sits in the source clock domain, directly upstream of the pulse clock-domain-crossing synchronizer.
- Accepts bursty single-cycle event pulses per lane and queues them as a pending count.
- Re-emits them as single-cycle pulses spaced at least gap_p cycles apart, so the downstream stretch/edge-detect crossing never merges or drops events.
- Flags lost events with a sticky overflow bit.

Parameters:
- width_p, 1, number of independent pulse lanes.
- gap_p, 4, minimum cycles between consecutive pulse_o rising edges per lane; must be >= 1; 1 = back-to-back allowed.
- pend_width_p, 4, pending-event counter width per lane; saturates at 2^pend_width_p-1.

Ports:
- clk_i  in  1  source-domain clock.
- reset_n_i  in  1  asynchronous active-low reset.
- en_i  in  1  emission enable, shared by all lanes.
- pulse_i  in  width_p  event pulses; each high cycle is one event.
- clear_ovf_i  in  width_p  clears overflow_o per lane.
- pulse_o  out  width_p  registered spaced pulses, to the synchronizer's src_i.
- busy_o  out  width_p  lane has pending events or is in cooldown.
- overflow_o  out  width_p  sticky: an event was dropped.

Behaviour:
- Reset: reset_n_i low asynchronously clears all per-lane state.
  - cnt=0, gcnt=0, pulse_o=0, overflow_o=0, busy_o=0.
  - Takes effect mid-cycle and mid-burst; pending events are discarded.
- Per-lane state:
  - cnt: pend_width_p bits.
  - gcnt: cooldown counter, $clog2(gap_p) bits, min 1 bit.
- Lane FSM derived from the counters:
  - IDLE: cnt=0, gcnt=0.
  - READY: cnt>0, gcnt=0.
  - COOL: gcnt>0.
- fire (combinational) = en_i & (gcnt==0) & (cnt!=0 | pulse_i[k]).
- pulse_o[k] <= fire, so latency from pulse_i in IDLE to pulse_o is 1 cycle. pulse_o is never high two consecutive cycles when gap_p>1.
- gcnt update:
  - fire: gcnt <= gap_p-1.
  - else if gcnt!=0: gcnt <= gcnt-1.
  - This gives exactly gap_p cycles between pulse_o edges under continuous backlog.
- cnt update: cnt <= cnt + pulse_i[k] - fire.
  - pulse_i and fire in the same cycle: net zero, including at cnt==max.
  - pulse_i & !fire & cnt==max: cnt holds, event dropped, overflow_o set next cycle.
- overflow_o: set has priority over clear_ovf_i in the same cycle; otherwise clear_ovf_i clears it next cycle.
- en_i low:
  - No fire.
  - Incoming events still counted.
  - gcnt keeps decrementing.
  - When en_i returns high with gcnt==0 and cnt>0, fire occurs that cycle.
- busy_o[k] = (cnt!=0) | (gcnt!=0), decoded from registers with no input path.
- Lanes are fully independent; no cross-lane arbitration.
- A level held high on pulse_i for N cycles counts as N events.

Decomposition:
- Shared qcl_pkg holds only the cooldown-width helper (clog2 with min 1); no typedefs are required.
- One sub-module, qcl_pulse_spacer_lane, implements the single-lane FSM/counters.
- The top generates width_p instances with shared clk_i, reset_n_i and en_i.

Test Plan:
- Async reset: assert reset_n_i mid-cycle during a backlog of cnt=3 -> pulse_o, busy_o, overflow_o drop to 0 immediately; after release, no further pulses until a new pulse_i.
- Single event, gap_p=4: pulse_i at cycle t -> pulse_o high at t+1 only; busy_o high t+1..t+3, low at t+4.
- Burst, gap_p=4: pulse_i at t, t+1, t+2 -> pulse_o at t+1, t+5, t+9 exactly; busy_o low from t+12.
- Overflow, gap_p=4, pend_width_p=2: pulse_i high t..t+5 -> overflow_o rises at t+6; pulse_o at t+1, t+5, t+9, t+13, t+17 (5 of 6 events); clear_ovf_i at t+20 -> overflow_o low at t+21.
- Enable gating: en_i=0, 3 events at t..t+2, en_i=1 at t+10 -> pulse_o at t+11, t+15, t+19; nothing before t+11.
- gap_p=1 pass-through: pulse_i high t..t+3 -> pulse_o high t+1..t+4; cnt stays 0; busy_o never asserts.
